// File: rtl/ram8_ctrl_pkg.sv
// Shared definitions for the ram8 sequencing controller.
// Provides the controller state encoding, the RAM geometry constants and
// the two-way round-robin selection helper used by rr_arbiter2.
package ram8_ctrl_pkg;

    localparam int RAM8_ADDR_W = 3;
    localparam int RAM8_DATA_W = 16;
    localparam int RAM8_DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    // One-hot pick between two requesters; on a tie the port that did not
    // win last time is chosen (last = index of the previous winner).
    function automatic logic [1:0] rr_choose(input logic [1:0] req, input logic last);
        logic [1:0] pick;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   req[1:0]       : request vector (bit N = port N)
//   advance        : a grant is being issued this cycle; remember the winner
//   pick[1:0]      : one-hot winner, all-zero when nothing is requested
// The last-winner register resets to 1 so port 0 takes the first tie.
module rr_arbiter2
    import ram8_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] pick
);

    logic last_r;

    // Combinational winner selection from the request vector and history.
    always_comb begin
        pick = rr_choose(req, last_r);
    end

    // Last-winner register; only moves when a grant is actually issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= 1'b1;
        end else if (advance) begin
            last_r <= pick[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/ram8_ctrl.sv
// Sequencing controller in front of a single ram8 (8 x 16-bit words).
// After reset it optionally fills every word with INIT_VALUE, then shares
// the RAM between two requesters using round-robin arbitration. Each
// accepted command costs one ACCESS cycle followed by one IDLE cycle.
// Ports:
//   clock, reset_n          : clock and asynchronous active-low reset
//   reqN/weN/addrN/wdataN   : command from port N, held until gntN
//   gntN                    : pulse, command of port N executing this cycle
//   ackN                    : pulse, access of port N complete
//   rdataN                  : read data of port N, held between reads
//   ready                   : high once the init sweep has finished
//   ram_in/ram_load/ram_address : drive the ram8 instance
//   ram_out                 : combinational read data from the ram8
// All outputs come straight from registers; next values are computed in
// one combinational block so the RAM controls line up with the state.
module ram8_ctrl
    import ram8_ctrl_pkg::*;
#(
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter logic [15:0] INIT_VALUE    = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [2:0]  addr0,
    input  logic [2:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        ready,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [2:0]  ram_address,
    input  logic [15:0] ram_out
);

    localparam state_e      RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_IDLE;
    localparam logic        RESET_LOAD  = INIT_ON_RESET;
    localparam logic [15:0] RESET_IN    = INIT_ON_RESET ? INIT_VALUE : 16'h0000;
    localparam logic [2:0]  LAST_ADDR   = 3'(RAM8_DEPTH - 1);

    state_e      state_r,     state_s;
    logic [2:0]  init_cnt_r,  init_cnt_s;
    logic        cmd_we_r,    cmd_we_s;
    logic [2:0]  cmd_addr_r,  cmd_addr_s;
    logic [15:0] cmd_wdata_r, cmd_wdata_s;
    logic        cmd_port_r,  cmd_port_s;
    logic [1:0]  gnt_r,       gnt_s;
    logic [1:0]  ack_r,       ack_s;
    logic [15:0] rdata0_r,    rdata0_s;
    logic [15:0] rdata1_r,    rdata1_s;
    logic [15:0] ram_in_r,    ram_in_s;
    logic        ram_load_r,  ram_load_s;
    logic [2:0]  ram_addr_r,  ram_addr_s;
    logic [1:0]  arb_req_s;
    logic [1:0]  pick_s;
    logic        advance_s;

    // Requests are only visible to the arbiter while idle, so nothing is
    // granted during init or while an access is executing.
    assign arb_req_s = (state_r == ST_IDLE) ? {req1, req0} : 2'b00;
    assign advance_s = |pick_s;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (arb_req_s),
        .advance (advance_s),
        .pick    (pick_s)
    );

    // Next-state, command capture and next values of every output register.
    always_comb begin
        state_s     = state_r;
        init_cnt_s  = init_cnt_r;
        cmd_we_s    = cmd_we_r;
        cmd_addr_s  = cmd_addr_r;
        cmd_wdata_s = cmd_wdata_r;
        cmd_port_s  = cmd_port_r;
        gnt_s       = 2'b00;
        ack_s       = 2'b00;
        rdata0_s    = rdata0_r;
        rdata1_s    = rdata1_r;
        ram_in_s    = ram_in_r;
        ram_load_s  = 1'b0;
        ram_addr_s  = ram_addr_r;
        case (state_r)
            ST_INIT: begin
                // ram_address already equals init_cnt; prepare the next word.
                if (init_cnt_r == LAST_ADDR) begin
                    state_s    = ST_IDLE;
                    init_cnt_s = 3'd0;
                end else begin
                    init_cnt_s = init_cnt_r + 3'd1;
                    ram_addr_s = init_cnt_r + 3'd1;
                    ram_in_s   = INIT_VALUE;
                    ram_load_s = 1'b1;
                end
            end
            ST_IDLE: begin
                if (advance_s) begin
                    state_s     = ST_ACCESS;
                    cmd_port_s  = pick_s[1];
                    cmd_we_s    = pick_s[1] ? we1    : we0;
                    cmd_addr_s  = pick_s[1] ? addr1  : addr0;
                    cmd_wdata_s = pick_s[1] ? wdata1 : wdata0;
                    gnt_s       = pick_s;
                    ram_addr_s  = cmd_addr_s;
                    ram_in_s    = cmd_wdata_s;
                    ram_load_s  = cmd_we_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // The write commits on this edge; a read captures ram_out.
                state_s = ST_IDLE;
                ack_s   = cmd_port_r ? 2'b10 : 2'b01;
                if (cmd_we_r) begin
                    rdata0_s = rdata0_r;
                    rdata1_s = rdata1_r;
                end else if (cmd_port_r) begin
                    rdata1_s = ram_out;
                end else begin
                    rdata0_s = ram_out;
                end
            end
            default: begin
                state_s    = RESET_STATE;
                init_cnt_s = 3'd0;
            end
        endcase
    end

    // State, command register and all output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= RESET_STATE;
            init_cnt_r  <= 3'd0;
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= 3'd0;
            cmd_wdata_r <= 16'h0000;
            cmd_port_r  <= 1'b0;
            gnt_r       <= 2'b00;
            ack_r       <= 2'b00;
            rdata0_r    <= 16'h0000;
            rdata1_r    <= 16'h0000;
            ram_in_r    <= RESET_IN;
            ram_load_r  <= RESET_LOAD;
            ram_addr_r  <= 3'd0;
        end else begin
            state_r     <= state_s;
            init_cnt_r  <= init_cnt_s;
            cmd_we_r    <= cmd_we_s;
            cmd_addr_r  <= cmd_addr_s;
            cmd_wdata_r <= cmd_wdata_s;
            cmd_port_r  <= cmd_port_s;
            gnt_r       <= gnt_s;
            ack_r       <= ack_s;
            rdata0_r    <= rdata0_s;
            rdata1_r    <= rdata1_s;
            ram_in_r    <= ram_in_s;
            ram_load_r  <= ram_load_s;
            ram_addr_r  <= ram_addr_s;
        end
    end

    assign gnt0        = gnt_r[0];
    assign gnt1        = gnt_r[1];
    assign ack0        = ack_r[0];
    assign ack1        = ack_r[1];
    assign rdata0      = rdata0_r;
    assign rdata1      = rdata1_r;
    assign ready       = (state_r != ST_INIT);
    assign ram_in      = ram_in_r;
    assign ram_load    = ram_load_r;
    assign ram_address = ram_addr_r;

endmodule

// File: tb/tb_ram8_ctrl.sv
// Scoreboard bench for ram8_ctrl: a sequencer hands command batches to a
// behavioural model (plain memory array + round-robin rule) which predicts
// grant order and per-port responses; a driver feeds the commands to the
// DUT and a monitor compares whatever the DUT presents.
module tb_ram8_ctrl;

    typedef struct packed { logic we; logic [2:0] addr; logic [15:0] wdata; } cmd_t;
    typedef struct packed { logic is_rd; logic [15:0] data; } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [2:0]  addr0 = 3'd0, addr1 = 3'd0;
    logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
    logic        gnt0, gnt1, ack0, ack1, ready, ram_load;
    logic [15:0] rdata0, rdata1, ram_in, ram_out;
    logic [2:0]  ram_address;

    logic [15:0] mem [8];
    bit          scramble = 1'b1;

    int pass_cnt = 0;
    int total_cnt = 0;

    cmd_t stage0[$], stage1[$], cmdq0[$], cmdq1[$];
    exp_t expq0[$], expq1[$];
    int   exp_gnt[$];

    logic [15:0] ref_mem [8];
    int          mdl_last;
    logic [15:0] mdl_rd0, mdl_rd1;

    ram8_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1), .ready(ready),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
        .ram_out(ram_out)
    );

    always #5 clock = ~clock;

    // ram8 stand-in: garbage contents until scramble drops, then normal.
    always @(posedge clock) begin
        if (scramble) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'($urandom);
        end else if (ram_load) begin
            mem[ram_address] <= ram_in;
        end
    end
    assign ram_out = mem[ram_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic cmd_t mk(input logic w, input logic [2:0] a, input logic [15:0] d);
        cmd_t c;
        c.we = w; c.addr = a; c.wdata = d;
        return c;
    endfunction

    // Reference model: serve staged commands in round-robin order.
    task automatic model_batch();
        cmd_t c;
        exp_t e;
        int   w;
        while (stage0.size() > 0 || stage1.size() > 0) begin
            if (stage0.size() > 0 && stage1.size() > 0) w = (mdl_last == 1) ? 0 : 1;
            else w = (stage0.size() > 0) ? 0 : 1;
            if (w == 0) begin c = stage0.pop_front(); cmdq0.push_back(c); end
            else begin c = stage1.pop_front(); cmdq1.push_back(c); end
            if (c.we) begin
                ref_mem[c.addr] = c.wdata;
                e.is_rd = 1'b0;
                e.data  = (w == 0) ? mdl_rd0 : mdl_rd1;
            end else begin
                if (w == 0) mdl_rd0 = ref_mem[c.addr];
                else mdl_rd1 = ref_mem[c.addr];
                e.is_rd = 1'b1;
                e.data  = ref_mem[c.addr];
            end
            if (w == 0) expq0.push_back(e); else expq1.push_back(e);
            exp_gnt.push_back(w);
            mdl_last = w;
        end
    endtask

    // Driver: present the queue head, keep req up until granted.
    initial begin
        bit act0 = 1'b0, act1 = 1'b0;
        int wt0 = 0, wt1 = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                req0 = 1'b0; req1 = 1'b0; act0 = 1'b0; act1 = 1'b0;
            end else begin
                if (act0) begin
                    if (gnt0 || wt0 >= 40) begin
                        if (!gnt0) fail_now("gnt0_wait");
                        if (cmdq0.size() > 0) void'(cmdq0.pop_front());
                        act0 = 1'b0;
                    end else wt0++;
                end
                if (!act0 && cmdq0.size() > 0) begin
                    req0 = 1'b1; we0 = cmdq0[0].we; addr0 = cmdq0[0].addr;
                    wdata0 = cmdq0[0].wdata; act0 = 1'b1; wt0 = 0;
                end else if (!act0) req0 = 1'b0;
                if (act1) begin
                    if (gnt1 || wt1 >= 40) begin
                        if (!gnt1) fail_now("gnt1_wait");
                        if (cmdq1.size() > 0) void'(cmdq1.pop_front());
                        act1 = 1'b0;
                    end else wt1++;
                end
                if (!act1 && cmdq1.size() > 0) begin
                    req1 = 1'b1; we1 = cmdq1[0].we; addr1 = cmdq1[0].addr;
                    wdata1 = cmdq1[0].wdata; act1 = 1'b1; wt1 = 0;
                end else if (!act1) req1 = 1'b0;
            end
        end
    end

    // Monitor: grant order, ack timing and read data against the model.
    initial begin
        logic [1:0] prev_g = 2'b00;
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (!reset_n) prev_g = 2'b00;
            else begin
                if (!ready) chk("no_gnt_in_init", {30'd0, gnt1, gnt0}, 32'd0);
                if (gnt0 || gnt1) begin
                    chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
                    if (exp_gnt.size() == 0) fail_now("unexpected_gnt");
                    else chk("gnt_port", {31'd0, gnt1}, 32'(exp_gnt.pop_front()));
                end
                if (prev_g[0] || ack0) chk("ack0_timing", {31'd0, ack0}, {31'd0, prev_g[0]});
                if (prev_g[1] || ack1) chk("ack1_timing", {31'd0, ack1}, {31'd0, prev_g[1]});
                if (ack0) begin
                    if (expq0.size() == 0) fail_now("unexpected_ack0");
                    else begin e = expq0.pop_front(); chk(e.is_rd ? "rdata0_read" : "rdata0_hold", {16'd0, rdata0}, {16'd0, e.data}); end
                end
                if (ack1) begin
                    if (expq1.size() == 0) fail_now("unexpected_ack1");
                    else begin e = expq1.pop_front(); chk(e.is_rd ? "rdata1_read" : "rdata1_hold", {16'd0, rdata1}, {16'd0, e.data}); end
                end
                prev_g = {gnt1, gnt0};
            end
        end
    end

    // Enter with reset_n low: flush, check reset outputs, release, check sweep.
    task automatic init_phase(input bit with_req);
        stage0.delete(); stage1.delete(); cmdq0.delete(); cmdq1.delete();
        expq0.delete(); expq1.delete(); exp_gnt.delete();
        mdl_last = 1; mdl_rd0 = 16'h0; mdl_rd1 = 16'h0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
        @(negedge clock); #2;
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("init_addr", {29'd0, ram_address}, 32'(i));
            chk("init_load", {31'd0, ram_load}, 32'd1);
            chk("init_ready", {31'd0, ready}, 32'd0);
            if (with_req && i == 3) begin
                stage1.push_back(mk(1'b0, 3'd5, 16'h0));
                model_batch();
            end
            @(negedge clock); #2;
        end
        chk("ready_after_init", {31'd0, ready}, 32'd1);
        chk("load_after_init", {31'd0, ram_load}, 32'd0);
        if (with_req) begin
            chk("gnt1_first_idle", {31'd0, gnt1}, 32'd0);
            @(negedge clock); #2;
            chk("gnt1_after_idle", {31'd0, gnt1}, 32'd1);
        end
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((cmdq0.size() + cmdq1.size() + exp_gnt.size() + expq0.size() + expq1.size()) > 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) fail_now("drain_timeout");
        @(posedge clock); #1;
    endtask

    task automatic run_batch();
        model_batch();
        wait_quiet();
    endtask

    // Sequencer.
    initial begin
        int mode, n0, n1, k;
        repeat (3) @(negedge clock);
        scramble = 1'b0;
        init_phase(1'b1);
        wait_quiet();

        stage0.push_back(mk(1'b0, 3'd5, 16'h0));
        run_batch();

        // Write then read back, with explicit grant/ack latency checks.
        stage0.push_back(mk(1'b1, 3'd3, 16'hBEEF));
        stage0.push_back(mk(1'b0, 3'd3, 16'h0));
        model_batch();
        @(negedge clock); #2;
        @(negedge clock); #2;
        chk("gnt0_k1", {31'd0, gnt0}, 32'd1);
        @(negedge clock); #2;
        chk("ack0_k2", {31'd0, ack0}, 32'd1);
        wait_quiet();

        // Both ports hold requests continuously.
        stage0.push_back(mk(1'b1, 3'd1, 16'h1111));
        stage1.push_back(mk(1'b1, 3'd2, 16'h2222));
        run_batch();
        for (int i = 0; i < 4; i++) begin
            stage0.push_back(mk(1'b0, 3'd1, 16'h0));
            stage1.push_back(mk(1'b0, 3'd2, 16'h0));
        end
        run_batch();

        // Cross-port visibility; the write must not disturb rdata1.
        stage1.push_back(mk(1'b1, 3'd7, 16'h1234));
        run_batch();
        stage0.push_back(mk(1'b0, 3'd7, 16'h0));
        run_batch();

        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(0, 2);
            n0 = (mode != 1) ? $urandom_range(1, 3) : 0;
            n1 = (mode != 0) ? $urandom_range(1, 3) : 0;
            for (int i = 0; i < n0; i++)
                stage0.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom)));
            for (int i = 0; i < n1; i++)
                stage1.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom)));
            run_batch();
        end

        // Reset during the ACCESS cycle of a write.
        stage0.push_back(mk(1'b1, 3'd6, 16'hDEAD));
        model_batch();
        k = 0;
        do begin
            @(negedge clock); #2;
            k++;
        end while (!gnt0 && k < 20);
        if (!gnt0) fail_now("gnt0_before_reset");
        reset_n = 1'b0;
        init_phase(1'b0);
        wait_quiet();
        for (int i = 0; i < 8; i++) stage0.push_back(mk(1'b0, 3'(i), 16'h0));
        run_batch();

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
